// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with a per-register busy scoreboard.
//   Two combinational read ports, one clocked write port, x0 hardwired to zero.
//   The busy bit of a register is set at issue, cleared at writeback and cleared in bulk on flush.
//   Optional macro REGFILE_WB_BYPASS_EN forwards same-cycle writeback data to the read ports.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rs1_addr/rs2_addr     read addresses
//   rs1_data/rs2_data     combinational read data
//   rs1_busy/rs2_busy     read address has an outstanding producer
//   wr_en/wr_addr/wr_data writeback port
//   iss_en/iss_rd         issue of an instruction with destination iss_rd
//   flush                 clears every busy bit
//   busy_vec              registered busy bits, bit i is register i
module regfile_scoreboard #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned ADDR_W = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_W-1:0]      rs1_addr,
   input  logic [ADDR_W-1:0]      rs2_addr,
   output logic [XLEN-1:0]        rs1_data,
   output logic [XLEN-1:0]        rs2_data,
   output logic                   rs1_busy,
   output logic                   rs2_busy,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [XLEN-1:0]        wr_data,
   input  logic                   iss_en,
   input  logic [ADDR_W-1:0]      iss_rd,
   input  logic                   flush,
   output logic [(2**ADDR_W)-1:0] busy_vec
);

   localparam int unsigned NREGS = 2**ADDR_W;

   // x0 has no storage; index 0 is never addressed because reads of x0 are muxed to zero
   logic [XLEN-1:0]  regs_q [1:NREGS-1];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic             wr_hit;

   assign wr_hit = wr_en & (wr_addr != '0);

   // Register storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 1; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_hit) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   // Scoreboard next state: flush beats issue, issue beats writeback
   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
         end
         if (iss_en) begin
            busy_d[iss_rd] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   // Scoreboard state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

`ifdef REGFILE_WB_BYPASS_EN
   logic byp1;
   logic byp2;

   // Forwarding is gated by rst_n so outputs read zero while reset is held
   assign byp1 = rst_n & wr_hit & (rs1_addr == wr_addr);
   assign byp2 = rst_n & wr_hit & (rs2_addr == wr_addr);

   // Read ports with same-cycle writeback forwarding
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1_addr != '0) begin
         rs1_data = regs_q[rs1_addr];
      end
      if (rs2_addr != '0) begin
         rs2_data = regs_q[rs2_addr];
      end
      if (byp1) begin
         rs1_data = wr_data;
      end
      if (byp2) begin
         rs2_data = wr_data;
      end
   end

   assign rs1_busy = busy_q[rs1_addr] & ~byp1;
   assign rs2_busy = busy_q[rs2_addr] & ~byp2;
`else
   // Read ports return stored contents only
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1_addr != '0) begin
         rs1_data = regs_q[rs1_addr];
      end
      if (rs2_addr != '0) begin
         rs2_data = regs_q[rs2_addr];
      end
   end

   assign rs1_busy = busy_q[rs1_addr];
   assign rs2_busy = busy_q[rs2_addr];
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_regfile_scoreboard;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned NREGS  = 32;
`ifdef REGFILE_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] rs1_addr, rs2_addr;
   logic [XLEN-1:0]   rs1_data, rs2_data;
   logic              rs1_busy, rs2_busy;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [XLEN-1:0]   wr_data;
   logic              iss_en;
   logic [ADDR_W-1:0] iss_rd;
   logic              flush;
   logic [NREGS-1:0]  busy_vec;

   regfile_scoreboard #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_rd   (iss_rd),
      .flush    (flush),
      .busy_vec (busy_vec)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: architectural register values and one busy flag per register
   logic [XLEN-1:0] m_reg  [NREGS];
   bit              m_busy [NREGS];

   typedef struct {
      logic              wr_en;
      logic [ADDR_W-1:0] wr_addr;
      logic [XLEN-1:0]   wr_data;
      logic              iss_en;
      logic [ADDR_W-1:0] iss_rd;
      logic              flush;
      logic [ADDR_W-1:0] rs1;
      logic [ADDR_W-1:0] rs2;
      logic [XLEN-1:0]   e1;
      logic [XLEN-1:0]   e2;
      logic [NREGS-1:0]  ebusy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic we, input int wa, input logic [XLEN-1:0] wd,
                               input logic ie, input int ir, input logic fl,
                               input int r1, input int r2,
                               input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                               input logic [NREGS-1:0] eb);
      vec_t v;
      v.wr_en = we;  v.wr_addr = ADDR_W'(wa); v.wr_data = wd;
      v.iss_en = ie; v.iss_rd = ADDR_W'(ir);  v.flush = fl;
      v.rs1 = ADDR_W'(r1); v.rs2 = ADDR_W'(r2);
      v.e1 = e1; v.e2 = e2; v.ebusy = eb;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) begin
         m_reg[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   // Apply one rising edge to the model using the inputs currently driven
   task automatic model_edge();
      if (rst_n) begin
         for (int i = 1; i < NREGS; i++) begin
            if (flush)                          m_busy[i] = 1'b0;
            else if (iss_en && iss_rd == i)     m_busy[i] = 1'b1;
            else if (wr_en && wr_addr == i)     m_busy[i] = 1'b0;
         end
         if (wr_en && wr_addr != 0) m_reg[wr_addr] = wr_data;
      end
   endtask

   function automatic bit m_hit(input logic [ADDR_W-1:0] a);
      return BYP && rst_n && wr_en && (wr_addr != 0) && (wr_addr == a);
   endfunction

   function automatic logic [XLEN-1:0] m_rd(input logic [ADDR_W-1:0] a);
      if (a == 0) return '0;
      if (m_hit(a)) return wr_data;
      return m_reg[a];
   endfunction

   function automatic logic m_bz(input logic [ADDR_W-1:0] a);
      return m_busy[a] && !m_hit(a);
   endfunction

   function automatic logic [NREGS-1:0] m_vec();
      logic [NREGS-1:0] v;
      v = '0;
      for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic cmp(input string nm, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic check_model(input string tag);
      cmp({tag, " rs1_data"}, rs1_data, m_rd(rs1_addr));
      cmp({tag, " rs2_data"}, rs2_data, m_rd(rs2_addr));
      cmp({tag, " rs1_busy"}, 64'(rs1_busy), 64'(m_bz(rs1_addr)));
      cmp({tag, " rs2_busy"}, 64'(rs2_busy), 64'(m_bz(rs2_addr)));
      cmp({tag, " busy_vec"}, 64'(busy_vec), 64'(m_vec()));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
   endtask

   localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

   initial begin
      rst_n = 1'b0;
      rs1_addr = 5'd5; rs2_addr = 5'd0;
      idle_inputs();
      model_reset();
      #1;
      cmp("reset busy_vec", 64'(busy_vec), 64'd0);
      check_model("reset");
      #11 rst_n = 1'b1;

      // Directed vectors: each applies one edge, then reads with idle write/issue inputs
      tbl.push_back(mk(1, 5, 64'h0000_0000_DEAD_BEEF, 0, 0, 0, 5, 0, 64'hDEAD_BEEF, 0, 32'h0));
      tbl.push_back(mk(1, 0, ONES, 1, 0, 0, 0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 0, 1, 7, 0, 7, 7, 0, 0, 32'h80));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 7, 5, 0, 64'hDEAD_BEEF, 32'h80));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 32'h80));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6, 7, 0, 0, 32'h80));
      tbl.push_back(mk(1, 7, 64'd42, 0, 0, 0, 7, 7, 64'd42, 64'd42, 32'h0));
      tbl.push_back(mk(1, 9, 64'h11, 1, 9, 0, 9, 7, 64'h11, 64'd42, 32'h200));
      tbl.push_back(mk(0, 0, 0, 1, 3, 0, 3, 9, 0, 64'h11, 32'h208));
      tbl.push_back(mk(0, 0, 0, 1, 4, 0, 4, 3, 0, 0, 32'h218));
      tbl.push_back(mk(0, 0, 0, 1, 10, 0, 10, 4, 0, 0, 32'h618));
      tbl.push_back(mk(1, 12, 64'h55, 1, 12, 1, 12, 5, 64'h55, 64'hDEAD_BEEF, 32'h0));
      tbl.push_back(mk(1, 31, ONES, 0, 0, 0, 31, 31, ONES, ONES, 32'h0));
      tbl.push_back(mk(1, 30, 64'h1234, 1, 31, 0, 30, 31, 64'h1234, ONES, 32'h8000_0000));
      tbl.push_back(mk(0, 0, 0, 1, 31, 0, 31, 0, ONES, 0, 32'h8000_0000));
      tbl.push_back(mk(1, 31, 64'd0, 0, 0, 0, 31, 30, 0, 64'h1234, 32'h0));

      foreach (tbl[k]) begin
         wr_en = tbl[k].wr_en; wr_addr = tbl[k].wr_addr; wr_data = tbl[k].wr_data;
         iss_en = tbl[k].iss_en; iss_rd = tbl[k].iss_rd; flush = tbl[k].flush;
         tick();
         idle_inputs();
         rs1_addr = tbl[k].rs1; rs2_addr = tbl[k].rs2;
         #1;
         cmp($sformatf("vec%0d rs1_data", k), rs1_data, tbl[k].e1);
         cmp($sformatf("vec%0d rs2_data", k), rs2_data, tbl[k].e2);
         cmp($sformatf("vec%0d busy_vec", k), 64'(busy_vec), 64'(tbl[k].ebusy));
         cmp($sformatf("vec%0d rs1_busy", k), 64'(rs1_busy), 64'(tbl[k].ebusy[tbl[k].rs1]));
         cmp($sformatf("vec%0d rs2_busy", k), 64'(rs2_busy), 64'(tbl[k].ebusy[tbl[k].rs2]));
      end

      // Writeback cycle itself: stored value without forwarding, new value with it
      iss_en = 1'b1; iss_rd = 5'd5; tick(); idle_inputs();
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hCAFE_F00D_0000_0001;
      rs1_addr = 5'd5; rs2_addr = 5'd5;
      #1;
      cmp("wbcycle rs1_data", rs1_data, BYP ? 64'hCAFE_F00D_0000_0001 : 64'hDEAD_BEEF);
      cmp("wbcycle rs1_busy", 64'(rs1_busy), BYP ? 64'd0 : 64'd1);
      cmp("wbcycle busy_vec", 64'(busy_vec), 64'h20);
      check_model("wbcycle");
      tick(); idle_inputs(); #1;
      check_model("after wb");

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         wr_en    = 1'($urandom_range(0, 1));
         wr_addr  = ADDR_W'($urandom_range(0, NREGS - 1));
         wr_data  = {32'($urandom), 32'($urandom)};
         iss_en   = ($urandom_range(0, 9) < 4);
         iss_rd   = ADDR_W'($urandom_range(0, NREGS - 1));
         flush    = ($urandom_range(0, 19) == 0);
         rs1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, NREGS - 1));
         rs2_addr = ($urandom_range(0, 3) == 0) ? iss_rd : ADDR_W'($urandom_range(0, NREGS - 1));
         #1;
         check_model($sformatf("rnd%0d", n));
         tick();
      end
      idle_inputs();

      // Load x1..x31 = i*3 while issuing, then assert reset between edges mid-write
      for (int i = 1; i < NREGS; i++) begin
         wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = XLEN'(i * 3);
         iss_en = 1'b1; iss_rd = ADDR_W'(NREGS - i);
         tick();
      end
      idle_inputs();
      rs1_addr = 5'd10; rs2_addr = 5'd31;
      #1;
      cmp("loaded x10", rs1_data, 64'd30);
      cmp("loaded x31", rs2_data, 64'd93);
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = ONES; iss_en = 1'b1; iss_rd = 5'd6;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      cmp("async rst x10", rs1_data, 64'd0);
      cmp("async rst busy_vec", 64'(busy_vec), 64'd0);
      for (int i = 0; i < NREGS; i++) begin
         rs1_addr = ADDR_W'(i); rs2_addr = ADDR_W'(NREGS - 1 - i);
         #1;
         check_model($sformatf("inrst%0d", i));
      end
      idle_inputs();
      @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      check_model("post rst");
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'd7;
      tick(); idle_inputs();
      rs1_addr = 5'd2; rs2_addr = 5'd3;
      #1;
      cmp("first write after rst", rs1_data, 64'd7);
      check_model("post rst write");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
